// File: rtl/alsu_cmd_driver.sv
// Command sequencer in front of the ALSU: buffers packed commands, issues them one at a time,
// waits out the ALSU pipeline and returns the captured result over valid/ready.
module alsu_cmd_driver #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ALSU_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  output logic [2:0]  alsu_a,
  output logic [2:0]  alsu_b,
  output logic [2:0]  alsu_opcode,
  output logic        alsu_cin,
  output logic        alsu_serial_in,
  output logic        alsu_op_a,
  output logic        alsu_op_b,
  output logic        alsu_bypass_A,
  output logic        alsu_bypass_B,
  input  logic [5:0]  alsu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  rsp_data,
  output logic        rsp_err,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam int unsigned AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = (ALSU_LAT < 1) ? 1 : $clog2(ALSU_LAT + 1);

  // Bit 15 of cmd_data is reserved and never stored.
  typedef struct packed {
    logic       bypass_b;
    logic       bypass_a;
    logic       op_b;
    logic       op_a;
    logic       serial_in;
    logic       cin;
    logic [2:0] opcode;
    logic [2:0] b;
    logic [2:0] a;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e          state_q, state_d;
  cmd_t            mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  cmd_t            cur_q, drv_q, head;
  logic [WW-1:0]   wait_cnt_q;
  logic [5:0]      rsp_data_q;
  logic            rsp_err_q;
  logic [7:0]      err_cnt_q;
  logic            push, pop, head_illegal, wait_done;

  assign cmd_ready    = (count_q != CW'(FIFO_DEPTH));
  assign push         = cmd_valid & cmd_ready;
  assign pop          = (state_q == StIdle) && (count_q != '0);
  assign head         = mem_q[rd_ptr_q];
  assign head_illegal = (head.opcode[2:1] == 2'b11);
  assign wait_done    = (wait_cnt_q == WW'(ALSU_LAT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (pop) state_d = head_illegal ? StHold : StIssue;
      StIssue: state_d = StWait;
      StWait:  if (wait_done) state_d = StHold;
      StHold:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Storage is not reset; validity is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_t'(cmd_data[14:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cur_q      <= '0;
      drv_q      <= '0;
      wait_cnt_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      if (pop) begin
        cur_q <= head;
        if (head_illegal) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
          if (err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
        end
      end

      if (state_q == StIssue) begin
        drv_q      <= cur_q;
        wait_cnt_q <= '0;
      end

      if (state_q == StWait) begin
        wait_cnt_q <= wait_cnt_q + WW'(1);
        if (wait_done) begin
          rsp_data_q <= alsu_out;
          rsp_err_q  <= 1'b0;
        end
      end
    end
  end

  assign alsu_a         = drv_q.a;
  assign alsu_b         = drv_q.b;
  assign alsu_opcode    = drv_q.opcode;
  assign alsu_cin       = drv_q.cin;
  assign alsu_serial_in = drv_q.serial_in;
  assign alsu_op_a      = drv_q.op_a;
  assign alsu_op_b      = drv_q.op_b;
  assign alsu_bypass_A  = drv_q.bypass_a;
  assign alsu_bypass_B  = drv_q.bypass_b;

  assign rsp_valid = (state_q == StHold);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// Bench for alsu_cmd_driver: a stand-in two-stage ALSU, a response scoreboard fed from the
// command handshake, a directed vector table and randomized traffic.
module tb_alsu_cmd_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_data = '0;
  logic [2:0]  alsu_a, alsu_b, alsu_opcode;
  logic        alsu_cin, alsu_serial_in, alsu_op_a, alsu_op_b, alsu_bypass_A, alsu_bypass_B;
  logic [5:0]  alsu_out;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [5:0]  rsp_data;
  logic        rsp_err;
  logic [7:0]  err_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int bad_op = 0;
  int rsp_cnt = 0;
  int err_exp = 0;
  logic [6:0] exp_q[$];

  alsu_cmd_driver #(.FIFO_DEPTH(4), .ALSU_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .alsu_a(alsu_a), .alsu_b(alsu_b), .alsu_opcode(alsu_opcode),
    .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_op_a(alsu_op_a),
    .alsu_op_b(alsu_op_b), .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
    .alsu_out(alsu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in ALSU function over the packed 15-bit command fields.
  function automatic logic [5:0] alsu_f(input logic [14:0] c);
    logic [2:0] a, b;
    a = c[2:0];
    b = c[5:3];
    if (c[13]) return {3'b0, a};
    if (c[14]) return {3'b0, b};
    case (c[8:6])
      3'd0:    return {3'b0, a & b};
      3'd1:    return {3'b0, a ^ b};
      3'd2:    return 6'(a) + 6'(b) + 6'(c[9]);
      3'd3:    return 6'(a) * 6'(b);
      3'd4:    return {a[1:0], b, c[10]};
      3'd5:    return {b, a};
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [6:0] ref_rsp(input logic [15:0] d);
    if (d[8:7] == 2'b11) return 7'b100_0000;
    return {1'b0, alsu_f(d[14:0])};
  endfunction

  function automatic logic [15:0] mk(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] op, input logic cin, input logic sin,
                                     input logic ba, input logic bb);
    return {1'b0, bb, ba, 1'b0, 1'b0, sin, cin, op, b, a};
  endfunction

  // Two register stages between the drive ports and alsu_out.
  logic [14:0] s1_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      alsu_out <= '0;
    end else begin
      s1_q     <= {alsu_bypass_B, alsu_bypass_A, alsu_op_b, alsu_op_a, alsu_serial_in,
                   alsu_cin, alsu_opcode, alsu_b, alsu_a};
      alsu_out <= alsu_f(s1_q);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted command yields exactly one response, in order.
  initial begin
    logic [6:0] e;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        err_exp = 0;
      end else begin
        if (alsu_opcode[2:1] == 2'b11) bad_op++;
        if (rsp_valid && rsp_ready) begin
          rsp_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got %0h expected none", {rsp_err, rsp_data});
          end else begin
            e = exp_q.pop_front();
            chk("rsp_sb", 32'({rsp_err, rsp_data}), 32'(e));
          end
        end
        if (cmd_valid && cmd_ready) begin
          exp_q.push_back(ref_rsp(cmd_data));
          if (cmd_data[8:7] == 2'b11 && err_exp < 255) err_exp++;
        end
      end
    end
  end

  task automatic push(input logic [15:0] d);
    int t = 0;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("push_ready", 32'(cmd_ready), 32'd1);
    if (cmd_ready) begin
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int t = 0;
    while (!rsp_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy || rsp_valid) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp"}, 32'({rsp_err, rsp_data}), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_drive"}, 32'({alsu_bypass_B, alsu_bypass_A, alsu_op_b, alsu_op_a,
        alsu_serial_in, alsu_cin, alsu_opcode, alsu_b, alsu_a}), 32'd0);
  endtask

  typedef struct {
    logic [15:0] cmd;
    logic [5:0]  data;
    logic        err;
  } vec_t;

  vec_t vt[8];

  initial begin
    int t, n, saw, rc0;

    vt[0] = '{mk(3'd3, 3'd5, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0), 6'd9,  1'b0};
    vt[1] = '{mk(3'd7, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0), 6'd6,  1'b0};
    vt[2] = '{mk(3'd5, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0), 6'd6,  1'b0};
    vt[3] = '{mk(3'd7, 3'd7, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0), 6'd49, 1'b0};
    vt[4] = '{mk(3'd1, 3'd2, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0), 6'd21, 1'b0};
    vt[5] = '{mk(3'd1, 3'd2, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0), 6'd17, 1'b0};
    vt[6] = '{mk(3'd4, 3'd1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0), 6'd4,  1'b0};
    vt[7] = '{mk(3'd2, 3'd2, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0), 6'd0,  1'b1};

    // Reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_reset_outputs("reset");

    // Legal op, exact latency from push edge P
    cmd_data  = vt[0].cmd;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("lat_busy", 32'(busy), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("lat_drive", 32'({alsu_a, alsu_b, alsu_opcode, alsu_cin}), 32'({3'd3, 3'd5, 3'd2, 1'b1}));
    repeat (2) @(posedge clk);
    #1;
    chk("lat_early", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", 32'(rsp_valid), 32'd1);
    chk("lat_rsp", 32'({rsp_err, rsp_data}), 32'd9);
    @(posedge clk); #1;
    chk("hold_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'({1'b1, 1'b0, 6'd9}));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hs_drop", 32'(rsp_valid), 32'd0);

    // Directed vector table
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(vt[i].cmd);
      wait_rsp();
      chk($sformatf("vec%0d_data", i), 32'(rsp_data), 32'(vt[i].data));
      chk($sformatf("vec%0d_err", i), 32'(rsp_err), 32'(vt[i].err));
      if (!vt[i].err) chk($sformatf("vec%0d_op", i), 32'(alsu_opcode), 32'(vt[i].cmd[8:6]));
      @(posedge clk); #1;
    end
    chk("vec_err_cnt", 32'(err_cnt), 32'd1);

    // Backpressure: 5 accepted, the 6th stalls until responses drain
    rsp_ready = 1'b0;
    rc0 = rsp_cnt;
    for (int i = 0; i < 5; i++) push(mk(3'(i), 3'(i + 1), 3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("full_ready", 32'(cmd_ready), 32'd0);
    cmd_data  = mk(3'd6, 3'd6, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    cmd_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("full_stall", 32'(cmd_ready), 32'd0);
    chk("full_accepted", 32'(exp_q.size()), 32'd5);
    rsp_ready = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("full_resume", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    drain();
    chk("full_rsp_count", 32'(rsp_cnt - rc0), 32'd6);

    // Illegal pair
    push(mk(3'd1, 3'd1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0));
    push(mk(3'd2, 3'd3, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0));
    drain();
    chk("illegal_err_cnt", 32'(err_cnt), 32'd3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_data  = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    chk("rand_err_cnt", 32'(err_cnt), 32'(err_exp));

    // Saturation
    cmd_data  = mk(3'd1, 3'd1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    cmd_valid = 1'b1;
    n = 0;
    t = 0;
    while (n < 260 && t < 5000) begin
      if (cmd_ready) n++;
      @(posedge clk); #1;
      t++;
    end
    cmd_valid = 1'b0;
    chk("sat_pushed", 32'(n), 32'd260);
    drain();
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);

    // Reset one cycle after the issue edge, two entries queued
    rsp_ready = 1'b0;
    push(mk(3'd1, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    push(mk(3'd2, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    push(mk(3'd3, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    saw = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rsp_valid) saw = 1;
    end
    chk("midrst_no_rsp", 32'(saw), 32'd0);
    chk("midrst_idle", 32'({busy, cmd_ready}), 32'b01);
    push(mk(3'd2, 3'd6, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_rsp();
    chk("post_rst_rsp", 32'({rsp_err, rsp_data}), 32'd12);
    @(posedge clk); #1;
    drain();

    chk("never_illegal_op", 32'(bad_op), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
